// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to instruction
// memory and hands fetched words to decode through a one-entry skid buffer.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst_code,
    output logic [31:0] o_pc_addr,
    output logic        o_inst_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic [31:0] r_next_pc;
    logic [31:0] r_inst_code;
    logic [31:0] r_pc_addr;
    logic        r_inst_valid;
    logic [31:0] r_skid;
    logic [31:0] r_skid_pc;

    logic        w_imem_req_nxt;
    logic [31:0] w_imem_addr_nxt;
    logic [31:0] w_next_pc_nxt;
    logic [31:0] w_inst_code_nxt;
    logic [31:0] w_pc_addr_nxt;
    logic        w_inst_valid_nxt;
    logic [31:0] w_skid_nxt;
    logic [31:0] w_skid_pc_nxt;

    logic [31:0] w_target;
    logic        w_slot_free;
    logic        w_done;
    logic        w_issue;

    // Next-state and datapath decode; a redirect only changes where the next issue goes.
    always_comb begin
        w_target         = i_branch_taken ? {i_branch_addr[31:2], 2'b00} : r_next_pc;
        w_slot_free      = !r_inst_valid || !i_stall;
        w_done           = r_imem_req && i_imem_ack;

        w_state_nxt      = r_state;
        w_imem_addr_nxt  = r_imem_addr;
        w_next_pc_nxt    = r_next_pc;
        w_inst_code_nxt  = r_inst_code;
        w_pc_addr_nxt    = r_pc_addr;
        w_inst_valid_nxt = r_inst_valid;
        w_skid_nxt       = r_skid;
        w_skid_pc_nxt    = r_skid_pc;
        w_issue          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_issue     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    if (w_slot_free) begin
                        w_inst_code_nxt  = i_imem_rdata;
                        w_pc_addr_nxt    = r_imem_addr;
                        w_inst_valid_nxt = 1'b1;
                        w_issue          = 1'b1;
                        w_state_nxt      = S_WAIT;
                    end else begin
                        // Decode still holds its word: park the returned one.
                        w_skid_nxt    = i_imem_rdata;
                        w_skid_pc_nxt = r_imem_addr;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (!i_stall) begin
                    w_inst_valid_nxt = 1'b0;
                end else begin
                    w_inst_valid_nxt = r_inst_valid;
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    w_inst_code_nxt  = r_skid;
                    w_pc_addr_nxt    = r_skid_pc;
                    w_inst_valid_nxt = 1'b1;
                    w_issue          = 1'b1;
                    w_state_nxt      = S_WAIT;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_inst_valid_nxt = 1'b0;
            end
        endcase

        if (w_issue) begin
            w_imem_addr_nxt = w_target;
            w_next_pc_nxt   = w_target + 32'd4;
        end else if (i_branch_taken) begin
            w_next_pc_nxt = w_target;
        end else begin
            w_next_pc_nxt = r_next_pc;
        end

        w_imem_req_nxt = (w_state_nxt == S_WAIT);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered memory interface, PC, decode outputs and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req   <= 1'b0;
            r_imem_addr  <= 32'h0000_0000;
            r_next_pc    <= RESET_PC;
            r_inst_code  <= 32'h0000_0000;
            r_pc_addr    <= 32'h0000_0000;
            r_inst_valid <= 1'b0;
            r_skid       <= 32'h0000_0000;
            r_skid_pc    <= 32'h0000_0000;
        end else begin
            r_imem_req   <= w_imem_req_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_next_pc    <= w_next_pc_nxt;
            r_inst_code  <= w_inst_code_nxt;
            r_pc_addr    <= w_pc_addr_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_skid       <= w_skid_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_imem_addr;
    assign o_inst_code  = r_inst_code;
    assign o_pc_addr    = r_pc_addr;
    assign o_inst_valid = r_inst_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; memory returns ~address as data.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_addr;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_inst_code;
    logic [31:0] o_pc_addr;
    logic        o_inst_valid;

    int checks = 0;
    int errors = 0;

    logic mem_en;
    logic mem_force;
    int   mem_delay;
    int   wait_cnt;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_stall       (i_stall),
        .i_branch_taken(i_branch_taken),
        .i_branch_addr (i_branch_addr),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_inst_code   (o_inst_code),
        .o_pc_addr     (o_pc_addr),
        .o_inst_valid  (o_inst_valid)
    );

    always #5 clk = ~clk;

    // Memory model: ack after mem_delay extra cycles of req; mem_force raises ack regardless of req.
    assign i_imem_ack   = mem_force || (mem_en && o_imem_req && (wait_cnt >= mem_delay));
    assign i_imem_rdata = ~o_imem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (o_imem_req && !i_imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int delay);
        @(negedge clk);
        rst_n          = 1'b0;
        i_stall        = 1'b0;
        i_branch_taken = 1'b0;
        i_branch_addr  = 32'h0000_0000;
        mem_en         = 1'b1;
        mem_force      = 1'b0;
        mem_delay      = delay;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code} !== 98'd0) begin
            errors++;
            $display("FAIL reset_values: got req=%b addr=%h valid=%b pc=%h code=%h, expected all zero",
                     o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid} !== {1'b1, RST_PC, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_issue: got req=%b addr=%h valid=%b, expected 1 %h 0",
                     o_imem_req, o_imem_addr, o_inst_valid, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ea;
        logic [31:0] ep;
        do_reset(0);
        tick();
        for (int c = 2; c <= 7; c++) begin
            tick();
            ea = RST_PC + 32'(4 * (c - 1));
            ep = RST_PC + 32'(4 * (c - 2));
            checks++;
            if ({o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code} !== {1'b1, ea, 1'b1, ep, ~ep}) begin
                errors++;
                $display("FAIL stream_c%0d: got req=%b addr=%h valid=%b pc=%h code=%h, expected 1 %h 1 %h %h",
                         c, o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code, ea, ep, ~ep);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] ea;
        logic [31:0] ep;
        logic        ev;
        do_reset(2);
        for (int c = 1; c <= 10; c++) begin
            tick();
            ea = RST_PC + 32'(4 * ((c - 1) / 3));
            ev = (c >= 4) && (((c - 1) % 3) == 0);
            checks++;
            if ({o_imem_req, o_imem_addr, o_inst_valid} !== {1'b1, ea, ev}) begin
                errors++;
                $display("FAIL wait_c%0d: got req=%b addr=%h valid=%b, expected 1 %h %b",
                         c, o_imem_req, o_imem_addr, o_inst_valid, ea, ev);
            end
            if (ev) begin
                ep = RST_PC + 32'(4 * ((c - 4) / 3));
                checks++;
                if ({o_pc_addr, o_inst_code} !== {ep, ~ep}) begin
                    errors++;
                    $display("FAIL wait_data_c%0d: got pc=%h code=%h, expected %h %h",
                             c, o_pc_addr, o_inst_code, ep, ~ep);
                end
            end
        end
    endtask

    task automatic test_stall_skid();
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] ea;
        logic [31:0] ep;
        a0 = RST_PC;
        a1 = RST_PC + 32'd4;
        do_reset(0);
        tick();
        tick();
        i_stall = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            tick();
            // Acks while req is low (HOLD) must be ignored.
            mem_force = (c >= 3 && c <= 5);
            checks++;
            if ({o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code} !== {1'b0, a1, 1'b1, a0, ~a0}) begin
                errors++;
                $display("FAIL stall_hold_c%0d: got req=%b addr=%h valid=%b pc=%h code=%h, expected 0 %h 1 %h %h",
                         c, o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code, a1, a0, ~a0);
            end
        end
        mem_force = 1'b0;
        i_stall   = 1'b0;
        for (int c = 7; c <= 9; c++) begin
            tick();
            ea = RST_PC + 32'(4 * (c - 5));
            ep = RST_PC + 32'(4 * (c - 6));
            checks++;
            if ({o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code} !== {1'b1, ea, 1'b1, ep, ~ep}) begin
                errors++;
                $display("FAIL stall_release_c%0d: got req=%b addr=%h valid=%b pc=%h code=%h, expected 1 %h 1 %h %h",
                         c, o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code, ea, ep, ~ep);
            end
        end
    endtask

    task automatic test_branch_outstanding();
        do_reset(2);
        for (int c = 1; c <= 13; c++) begin
            tick();
        end
        checks++;
        if ({o_imem_req, o_imem_addr} !== {1'b1, 32'hBFC0_0010}) begin
            errors++;
            $display("FAIL br_pre: got req=%b addr=%h, expected 1 bfc00010", o_imem_req, o_imem_addr);
        end
        i_branch_taken = 1'b1;
        i_branch_addr  = 32'h8000_0100;
        tick();
        i_branch_taken = 1'b0;
        i_branch_addr  = 32'h0000_0000;
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid} !== {1'b1, 32'hBFC0_0010, 1'b0}) begin
            errors++;
            $display("FAIL br_not_cancelled: got req=%b addr=%h valid=%b, expected 1 bfc00010 0",
                     o_imem_req, o_imem_addr, o_inst_valid);
        end
        tick();
        tick();
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code} !==
            {1'b1, 32'h8000_0100, 1'b1, 32'hBFC0_0010, ~32'hBFC0_0010}) begin
            errors++;
            $display("FAIL br_delay_slot: got req=%b addr=%h valid=%b pc=%h code=%h, expected 1 80000100 1 bfc00010 403fffef",
                     o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code} !==
            {1'b1, 32'h8000_0104, 1'b1, 32'h8000_0100, ~32'h8000_0100}) begin
            errors++;
            $display("FAIL br_target: got req=%b addr=%h valid=%b pc=%h code=%h, expected 1 80000104 1 80000100 7ffffeff",
                     o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code);
        end
    endtask

    task automatic test_branch_on_ack();
        do_reset(0);
        tick();
        i_branch_taken = 1'b1;
        i_branch_addr  = 32'h8000_0013;
        tick();
        i_branch_taken = 1'b0;
        i_branch_addr  = 32'h0000_0000;
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code} !== {1'b1, 32'h8000_0010, 1'b1, RST_PC, ~RST_PC}) begin
            errors++;
            $display("FAIL br_ack_issue: got req=%b addr=%h valid=%b pc=%h code=%h, expected 1 80000010 1 bfc00000 403fffff",
                     o_imem_req, o_imem_addr, o_inst_valid, o_pc_addr, o_inst_code);
        end
        tick();
        checks++;
        if ({o_imem_addr, o_pc_addr, o_inst_code} !== {32'h8000_0014, 32'h8000_0010, ~32'h8000_0010}) begin
            errors++;
            $display("FAIL br_ack_next: got addr=%h pc=%h code=%h, expected 80000014 80000010 7fffffef",
                     o_imem_addr, o_pc_addr, o_inst_code);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        tick();
        i_branch_taken = 1'b1;
        i_branch_addr  = 32'h8000_0100;
        tick();
        i_branch_addr  = 32'h9000_0202;
        tick();
        i_branch_taken = 1'b0;
        i_branch_addr  = 32'h0000_0000;
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid} !== {1'b1, RST_PC, 1'b0}) begin
            errors++;
            $display("FAIL b2b_pending: got req=%b addr=%h valid=%b, expected 1 bfc00000 0",
                     o_imem_req, o_imem_addr, o_inst_valid);
        end
        tick();
        checks++;
        if ({o_imem_addr, o_inst_valid, o_pc_addr} !== {32'h9000_0200, 1'b1, RST_PC}) begin
            errors++;
            $display("FAIL b2b_latest_wins: got addr=%h valid=%b pc=%h, expected 90000200 1 bfc00000",
                     o_imem_addr, o_inst_valid, o_pc_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset(0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_imem_req, o_inst_valid, o_inst_code, o_pc_addr, o_imem_addr} !== 98'd0) begin
            errors++;
            $display("FAIL async_reset: got req=%b valid=%b code=%h pc=%h addr=%h, expected all zero",
                     o_imem_req, o_inst_valid, o_inst_code, o_pc_addr, o_imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({o_imem_req, o_imem_addr, o_inst_valid} !== {1'b1, RST_PC, 1'b0}) begin
            errors++;
            $display("FAIL async_restart_issue: got req=%b addr=%h valid=%b, expected 1 bfc00000 0",
                     o_imem_req, o_imem_addr, o_inst_valid);
        end
        tick();
        checks++;
        if ({o_inst_valid, o_pc_addr, o_inst_code} !== {1'b1, RST_PC, ~RST_PC}) begin
            errors++;
            $display("FAIL async_restart_data: got valid=%b pc=%h code=%h, expected 1 bfc00000 403fffff",
                     o_inst_valid, o_pc_addr, o_inst_code);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        i_stall        = 1'b0;
        i_branch_taken = 1'b0;
        i_branch_addr  = 32'h0000_0000;
        mem_en         = 1'b1;
        mem_force      = 1'b0;
        mem_delay      = 0;
        test_reset();
        test_stream();
        test_wait_states();
        test_stall_skid();
        test_branch_outstanding();
        test_branch_on_ack();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the program counter and runs a request/acknowledge handshake to instruction memory.
- Presents each fetched 32-bit instruction word and its address to decode.
- A one-entry skid buffer absorbs a fetch that completes while decode is stalled; branch/jump redirects arrive from later stages.

Parameters:
RESET_PC, 32'hBFC0_0000, address of the first fetch after reset (bits [1:0] must be 0)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; one clock; asynchronous, active-low
stall  input  1  decode cannot accept; output registers must hold
branch_taken  input  1  redirect request, sampled at rising edge
branch_addr  input  32  redirect target; bits [1:0] forced to 0 internally
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; stable while imem_req=1
imem_ack  input  1  memory completes the fetch this cycle; imem_rdata valid
imem_rdata  input  32  instruction word returned with imem_ack
inst_code  output  32  instruction word to decode
pc_addr  output  32  address of inst_code
inst_valid  output  1  inst_code/pc_addr hold a real instruction

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - state=S_IDLE.
  - imem_req=0, imem_addr=0, next_pc=RESET_PC.
  - inst_code=32'h0 (NOP), pc_addr=0, inst_valid=0.
  - Skid buffer empty.
- All outputs are registered. imem_req=1 exactly when state=S_WAIT.
- Target selection: target = branch_taken ? {branch_addr[31:2],2'b00} : next_pc.
  - Every issue does imem_addr<=target and next_pc<=target+4 (32-bit, wraps mod 2^32).
  - branch_taken with no issue on that edge does next_pc<=target only.
- Handshake:
  - A request completes on an edge where imem_req=1 and imem_ack=1.
  - imem_ack may arrive in the first cycle imem_req is high, giving one fetch per cycle.
  - Requests are never cancelled. imem_addr and imem_req stay stable until ack.
  - imem_ack while imem_req=0 is ignored.
- Output slot free = !inst_valid || !stall. Decode consumes on any edge with inst_valid=1 and stall=0.
- FSM states: S_IDLE, S_WAIT, S_HOLD.
- S_IDLE -> S_WAIT on first edge after reset release; issue target (RESET_PC unless branch_taken).
- S_WAIT, no ack:
  - Stay in S_WAIT.
  - If stall=0: inst_valid<=0 (bubble).
  - If stall=1: outputs hold.
- S_WAIT, ack, slot free:
  - inst_code<=imem_rdata, pc_addr<=imem_addr, inst_valid<=1.
  - Issue target; stay in S_WAIT.
- S_WAIT, ack, slot occupied (inst_valid=1 and stall=1):
  - skid<=imem_rdata, skid_pc<=imem_addr.
  - Go to S_HOLD (imem_req<=0); outputs hold.
- S_HOLD, stall=1: stay; outputs hold. branch_taken still updates next_pc.
- S_HOLD, stall=0:
  - inst_code<=skid, pc_addr<=skid_pc, inst_valid<=1.
  - Issue target; go to S_WAIT.
- Redirect semantics (MIPS delay slot):
  - An outstanding or skid-held fetch is delivered normally; nothing is flushed.
  - The next issued address is the target.
  - branch_taken on the same edge as an ack: the issue uses the target, not next_pc.
  - Back-to-back branch_taken: the latest one wins.
- Latency with zero-wait memory: first inst_valid=1 on the 2nd edge after reset release; one instruction per cycle after that.
- No instruction is lost or duplicated across any stall/ack/redirect combination.
- Reset mid-operation:
  - All registers return to reset values immediately.
  - The in-flight fetch is abandoned; memory must tolerate imem_req dropping.

Test Plan:
1. Reset release, memory acks whenever req=1, rdata=~addr:
   - imem_addr = BFC00000, BFC00004, BFC00008… on consecutive cycles.
   - inst_valid=1 from 2nd edge; pc_addr one cycle behind imem_addr; inst_code=~pc_addr.
2. Memory ack delayed 3 cycles per request, stall=0:
   - imem_req/imem_addr stable for 3 cycles.
   - inst_valid=0 on non-ack cycles; addresses strictly +4, none skipped.
3. stall=1 for 4 cycles while an ack arrives:
   - Outputs frozen; state S_HOLD; imem_req=0.
   - After stall drops: skid word appears next cycle, then the next sequential address is fetched; no duplicate or lost pc_addr.
4. branch_taken=1, branch_addr=80000100, pulsed while a fetch of BFC00010 is outstanding:
   - BFC00010 is delivered (delay slot); next imem_addr=80000100, then 80000104.
5. branch_taken coincident with ack, branch_addr=80000013:
   - Issued imem_addr=80000010; next_pc=80000014.
6. rst_n pulled low mid-S_WAIT (asynchronous, between edges):
   - imem_req, inst_valid, inst_code, pc_addr go to 0 without a clock edge.
   - After release, fetch restarts at BFC00000.
